// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins forced low/high or driven by one shared 8-bit PWM; pins registered (1 clk latency), no backpressure.
// Define PWM_SYNC_UPDATE_EN to double-buffer the duty value so it only changes at period boundaries.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV   = 13,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [CNT_WIDTH-1:0] DIV_LAST = CNT_WIDTH'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_ONE  = CNT_WIDTH'(1);
    localparam logic [7:0]           CNT_LAST = 8'd254;

    logic [CNT_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]           pwm_cnt_q, pwm_cnt_d;
    logic                 tick;
    logic                 wrap;
    logic [15:0]          en_out;
    logic [15:0]          en_pwm;
    logic [15:0]          out_q, out_d;
    logic                 period_start_q;
    logic [7:0]           duty_eff;
    logic                 pwm_hi;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Period is 255 ticks (0..254) so that duty 0xFF can mean "always high".
    assign tick = (div_cnt_q == DIV_LAST);
    assign wrap = tick && (pwm_cnt_q == CNT_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_ONE;
        pwm_cnt_d = pwm_cnt_q;
        if (tick) begin
            div_cnt_d = '0;
        end
        if (wrap) begin
            pwm_cnt_d = '0;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

`ifdef PWM_SYNC_UPDATE_EN
    logic [7:0] duty_q, duty_d;
    logic       upd_pending_q, upd_pending_d;

    // Load once straight after reset, then only on the wrap so a period never sees a duty change.
    always_comb begin
        duty_d        = duty_q;
        upd_pending_d = upd_pending_q;
        if (wrap || upd_pending_q) begin
            duty_d        = pwm_duty_cycle;
            upd_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q        <= 8'h00;
            upd_pending_q <= 1'b1;
        end else begin
            duty_q        <= duty_d;
            upd_pending_q <= upd_pending_d;
        end
    end

    assign duty_eff = duty_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    assign pwm_hi = (duty_eff == 8'hFF) || (pwm_cnt_q < duty_eff);

    always_comb begin
        out_d = en_out & (~en_pwm | {16{pwm_hi}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            period_start_q <= wrap;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (CLK_DIV=2 and CLK_DIV=1) against a cycle-count arithmetic model,
// plus a mux vector table and hand-timed pulse measurements.
module tb_pwm_peripheral;

`ifdef PWM_SYNC_UPDATE_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out2, out1;
    logic        ps2, ps1;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle(duty), .out(out2), .period_start(ps2)
    );

    pwm_peripheral #(.CLK_DIV(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: cycle k after reset release; tick count = k/D, counter = (k/D) mod 255,
    // periods last 255*D cycles and start at every multiple of that.
    int unsigned     mk[2];
    logic [15:0]     mexp_out[2];
    logic            mexp_ps[2];
    logic [7:0]      mduty[2];
    int unsigned     divs[2] = '{2, 1};
    int unsigned     sb_k, sb_p, sb_cnt;
    logic [7:0]      sb_deff;
    logic            sb_hi;
    logic [15:0]     sb_ao;
    logic            sb_ap;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            sb_ao = (i == 0) ? out2 : out1;
            sb_ap = (i == 0) ? ps2 : ps1;
            if (!rst_n) begin
                chk(i == 0 ? "rst_out_div2" : "rst_out_div1", sb_ao, 0);
                chk(i == 0 ? "rst_ps_div2" : "rst_ps_div1", sb_ap, 0);
                mk[i]       = 0;
                mexp_out[i] = '0;
                mexp_ps[i]  = 1'b0;
                mduty[i]    = 8'h00;
            end else begin
                chk(i == 0 ? "sb_out_div2" : "sb_out_div1", sb_ao, mexp_out[i]);
                chk(i == 0 ? "sb_ps_div2" : "sb_ps_div1", sb_ap, mexp_ps[i]);
                sb_k    = mk[i];
                sb_p    = 255 * divs[i];
                sb_cnt  = (sb_k / divs[i]) % 255;
                sb_deff = SYNC ? mduty[i] : duty;
                sb_hi   = (sb_deff == 8'hFF) || (sb_cnt < sb_deff);
                mexp_out[i] = {eo_hi, eo_lo} & (~{ep_hi, ep_lo} | {16{sb_hi}});
                mexp_ps[i]  = ((sb_k + 1) % sb_p) == 0;
                if (sb_k == 0 || ((sb_k + 1) % sb_p) == 0) mduty[i] = duty;
                mk[i] = sb_k + 1;
            end
        end
    end

    task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        @(posedge clk);
        #2;
        {eo_hi, eo_lo} = eo;
        {ep_hi, ep_lo} = ep;
        duty = d;
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (hold) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_ps(input int which);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if ((which == 0 ? ps2 : ps1) === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL wait_ps timeout: got no pulse expected pulse within 2000 clk");
        end
    endtask

    // Counts cycles j=1..n after the current cycle; optionally changes duty early in cycle chg_at.
    task automatic measure(input int n, input int which, input int chg_at, input logic [7:0] chg_duty,
                           output int hi_cnt, output int first_hi, output int ps_at);
        logic o, p;
        hi_cnt = 0; first_hi = 0; ps_at = 0;
        for (int j = 1; j <= n; j++) begin
            @(posedge clk);
            #2;
            if (j == chg_at) duty = chg_duty;
            @(negedge clk);
            o = (which == 0) ? out2[0] : out1[0];
            p = (which == 0) ? ps2 : ps1;
            if (o) begin
                hi_cnt++;
                if (first_hi == 0) first_hi = j;
            end
            if (p && ps_at == 0) ps_at = j;
        end
    endtask

    typedef struct {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  d;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];
    int   hi, fh, pa, cnt;

    initial begin
        rst_n = 1'b0;
        eo_lo = '0; eo_hi = '0; ep_lo = '0; ep_hi = '0; duty = '0;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
        vecs[1] = '{16'h00F0, 16'h0030, 8'hFF, 16'h00F0};
        vecs[2] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
        vecs[3] = '{16'hA5A5, 16'h0F0F, 8'hFF, 16'hA5A5};
        vecs[4] = '{16'h1234, 16'hFFFF, 8'hFF, 16'h1234};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
        vecs[6] = '{16'h00F0, 16'h0030, 8'h00, 16'h00C0};
        vecs[7] = '{16'h0000, 16'hFFFF, 8'h00, 16'h0000};
        vecs[8] = '{16'hA5A5, 16'h0F0F, 8'h00, 16'hA0A0};
        vecs[9] = '{16'hFFFF, 16'h0000, 8'h00, 16'hFFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", out2, 0);
        chk("reset_ps", ps2, 0);
        #2 rst_n = 1'b1;

        // Pin mux table; duty changes wait for a period boundary so both instances have adopted it.
        for (int r = 0; r < 10; r++) begin
            if (vecs[r].d != duty) begin
                set_in({eo_hi, eo_lo}, {ep_hi, ep_lo}, vecs[r].d);
                wait_ps(0);
            end
            set_in(vecs[r].eo, vecs[r].ep, vecs[r].d);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_div2", r), out2, vecs[r].exp);
            chk($sformatf("vec%0d_div1", r), out1, vecs[r].exp);
        end

        // Duty 0xFF holds high across wraps, then 0x00 holds low.
        set_in(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps(0);
        wait_ps(0);
        cnt = 0;
        for (int j = 0; j < 1100; j++) begin
            @(negedge clk);
            if (out2 != 16'hFFFF) cnt++;
        end
        chk("ff_no_dropout", cnt, 0);
        set_in(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps(0);
        measure(600, 0, 0, 8'h00, hi, fh, pa);
        chk("zero_const_low", hi, 0);

        // Duty 0x80 at CLK_DIV=2: 256 high, 254 low, period 510.
        set_in(16'hFFFF, 16'hFFFF, 8'h80);
        wait_ps(0);
        wait_ps(0);
        measure(510, 0, 0, 8'h80, hi, fh, pa);
        chk("d80_high_div2", hi, 256);
        chk("d80_period_div2", pa, 510);

        // Mid-period duty change 0x40 -> 0xC0.
        set_in(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps(0);
        wait_ps(0);
        measure(510, 0, 60, 8'hC0, hi, fh, pa);
        chk("chg_cur_period", hi, SYNC ? 128 : 384);
        measure(510, 0, 0, 8'hC0, hi, fh, pa);
        chk("chg_next_period", hi, 384);

        // CLK_DIV=1, duty 0x01: one-clk pulse right after each period_start.
        set_in(16'hFFFF, 16'hFFFF, 8'h01);
        wait_ps(1);
        wait_ps(1);
        measure(255, 1, 0, 8'h01, hi, fh, pa);
        chk("d01_high_div1", hi, 1);
        chk("d01_pos_div1", fh, 1);
        chk("d01_period_div1", pa, 255);

        // Reset during a high phase clears pins asynchronously; restart with duty 0x10.
        set_in(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps(0);
        cnt = 0;
        while (out2[0] !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("pre_reset_high", out2[0], 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out2", out2, 0);
        chk("async_rst_out1", out1, 0);
        duty = 8'h10;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        measure(100, 0, 0, 8'h10, hi, fh, pa);
        chk("rst_first_pulse_len", hi, SYNC ? 31 : 32);
        chk("rst_first_pulse_start", fh, SYNC ? 2 : 1);

        // Random enables/duty with occasional resets, checked by the model every cycle.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 7) == 0) do_reset($urandom_range(1, 3));
            set_in(16'($urandom), 16'($urandom), 8'($urandom));
            repeat ($urandom_range(1, 700)) @(posedge clk);
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five 8-bit control registers written over SPI: output enables, PWM enables and duty cycle.
- Drives 16 registered output pins.
- Each pin is forced low, forced high, or driven by one shared 8-bit PWM waveform.
- The PWM timebase is a clock prescaler plus a 255-step period counter; duty updates are glitch-free at period boundaries.

Parameters:
CLK_DIV, 13, clk cycles per PWM tick; legal range >=1; 10 MHz clk gives about 3.02 kHz PWM (10e6/(13*255))
CNT_WIDTH, 16, width of prescaler counter; must hold CLK_DIV-1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en_reg_out_7_0  in  8  output enable, pins 7..0
en_reg_out_15_8  in  8  output enable, pins 15..8
en_reg_pwm_7_0  in  8  PWM select, pins 7..0
en_reg_pwm_15_8  in  8  PWM select, pins 15..8
pwm_duty_cycle  in  8  duty value 0x00..0xFF
out  out  16  pin outputs
period_start  out  1  one-clk pulse at start of each PWM period

Behaviour:
- Reset: clk is clk, reset is rst_n (asynchronous, active-low). During reset:
  - out=0, period_start=0
  - div_cnt=0, pwm_cnt=0
  - duty_q=0, upd_pending=1
- All inputs are quasi-static register values in the clk domain; no synchronisers.
- Prescaler:
  - div_cnt counts 0..CLK_DIV-1.
  - tick=1 in the cycle where div_cnt==CLK_DIV-1; div_cnt then returns to 0.
  - CLK_DIV=1 gives tick every cycle.
- Period counter:
  - pwm_cnt increments on tick, over range 0..254 (255 ticks per period).
  - On tick with pwm_cnt==254, it wraps to 0 (wrap event).
- period_start: registered; =1 for exactly the clk cycle in which pwm_cnt first holds 0 after a wrap; otherwise 0. No pulse after reset.
- Duty capture (feature enabled):
  - duty_q <= pwm_duty_cycle on a wrap event, or in any cycle with upd_pending=1.
  - upd_pending clears after that first load, so duty_q is valid 1 clk after reset release.
- PWM level:
  - pwm_hi = (duty_q==8'hFF) | (pwm_cnt < duty_q).
  - 0x00 gives constant low; 0xFF gives constant high (no 1-tick dropout).
  - Otherwise high for duty_q ticks per 255-tick period.
- Pin mux per bit i (en_out/en_pwm = {15_8, 7_0} concatenations):
  - next_out[i] = en_out[i] ? (en_pwm[i] ? pwm_hi : 1) : 0.
  - out <= next_out every clk, so out follows input or counter changes with 1-clk latency.
  - en_pwm is ignored when en_out=0.
- All 16 PWM pins are in phase; they share pwm_hi.
- Simultaneous events:
  - A duty change on the wrap cycle is captured for the new period.
  - A duty change at any other cycle takes effect at the next wrap.
  - An enable change always takes effect after 1 clk, independent of period.
- Reset mid-period: immediately out=0, counters to 0. After release, the first period starts at pwm_cnt=0 with freshly captured duty.

Optional Feature:
Macro: PWM_SYNC_UPDATE_EN
- Defined: duty double-buffered via duty_q, updated only at wrap and after reset, as above.
- Undefined: duty_q and upd_pending are removed and pwm_hi uses pwm_duty_cycle directly. A duty change then affects the current period after 1 clk, so mid-period glitches and truncated pulses are permitted.
- Either way: prescaler, period_start and pin mux are identical.

Test Plan:
1. CLK_DIV=2, feature on, en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80 -> every pin high 256 clk, low 254 clk, period 510 clk; period_start spaced 510 clk.
2. duty=0x00 then 0xFF across several periods -> pins constant 0, then constant 1 from the next period start; no single-cycle glitch at wrap.
3. en_out=0x00F0, en_pwm=0x0030, duty=0x40 -> out[7:6]=1 static, out[5:4] PWM, all other bits 0; change en_out to 0 -> out=0 one clk later.
4. Feature on, duty 0x40 -> 0xC0 written mid-period -> current period high 128 clk (CLK_DIV=2), next period high 384 clk. Feature off -> high time changes within 1 clk of the write.
5. Assert rst_n low mid-PWM-high phase -> out=0 asynchronously. Release with duty=0x10 -> first high pulse is 32 clk, starting within 2 clk of release.
6. CLK_DIV=1, duty=0x01 -> 1-clk high pulse every 255 clk; period_start aligned with the cycle pwm_cnt==0.
